// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and taken-branch squashes for the
// 5-stage core, with multi-cycle penalties and saturating performance counters.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES      = 1,
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned CNT_W             = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic             ifid_use_rs1,
   input  logic             ifid_use_rs2,
   input  logic             ex_branch_taken,
   input  logic             perf_clear,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic             busy
);

   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0] STALL_LOAD = CW'(LOAD_STALL_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          lu_c;
   logic          flush_evt_c;

   assign lu_c = idex_memread & (idex_rd != 5'd0) &
                 ((ifid_use_rs1 & (idex_rd == ifid_rs1)) |
                  (ifid_use_rs2 & (idex_rd == ifid_rs2)));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Mealy control: reset > branch > state action > load-use
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      idex_bubble = 1'b0;
      flush_evt_c = 1'b0;
      if (reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_nxt  = RUN;
         cnt_nxt    = '0;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         flush_evt_c = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_LOAD;
         end else begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      end else begin
         case (state)
            LDSTALL: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               cnt_nxt     = cnt - CW'(1);
               if (cnt == CW'(1)) state_nxt = RUN;
            end
            FLUSH: begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               cnt_nxt    = cnt - CW'(1);
               if (cnt == CW'(1)) state_nxt = RUN;
            end
            default: begin
               if (lu_c) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_nxt = LDSTALL;
                     cnt_nxt   = STALL_LOAD;
                  end
               end
            end
         endcase
      end
   end

   // Saturating performance counters; clear wins over increment
   always_ff @(posedge clk) begin
      if (reset || perf_clear) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (idex_bubble && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_evt_c && (flush_events != {CNT_W{1'b1}}))
            flush_events <= flush_events + CNT_W'(1);
      end
   end

   assign busy = (state != RUN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one default instance and one with
// FLUSH_CYCLES=2, LOAD_STALL_CYCLES=3, CNT_W=4, sharing the same inputs.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       idex_memread;
   logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
   logic       ifid_use_rs1, ifid_use_rs2;
   logic       ex_branch_taken, perf_clear;

   logic        d_pc_write, d_ifid_write, d_ifid_flush, d_idex_flush, d_idex_bubble, d_busy;
   logic [31:0] d_stall_cycles, d_flush_events;
   logic        p_pc_write, p_ifid_write, p_ifid_flush, p_idex_flush, p_idex_bubble, p_busy;
   logic [3:0]  p_stall_cycles, p_flush_events;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl u_def (
      .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
      .ifid_use_rs2(ifid_use_rs2), .ex_branch_taken(ex_branch_taken),
      .perf_clear(perf_clear), .pc_write(d_pc_write), .ifid_write(d_ifid_write),
      .ifid_flush(d_ifid_flush), .idex_flush(d_idex_flush), .idex_bubble(d_idex_bubble),
      .stall_cycles(d_stall_cycles), .flush_events(d_flush_events), .busy(d_busy)
   );

   hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(3), .CNT_W(4)) u_par (
      .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
      .ifid_use_rs2(ifid_use_rs2), .ex_branch_taken(ex_branch_taken),
      .perf_clear(perf_clear), .pc_write(p_pc_write), .ifid_write(p_ifid_write),
      .ifid_flush(p_ifid_flush), .idex_flush(p_idex_flush), .idex_bubble(p_idex_bubble),
      .stall_cycles(p_stall_cycles), .flush_events(p_flush_events), .busy(p_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      idex_memread    = 1'b0;
      idex_rd         = 5'd0;
      ifid_rs1        = 5'd0;
      ifid_rs2        = 5'd0;
      ifid_use_rs1    = 1'b0;
      ifid_use_rs2    = 1'b0;
      ex_branch_taken = 1'b0;
      perf_clear      = 1'b0;
   endtask

   task automatic hazard_rs2(input logic [4:0] r);
      idex_memread = 1'b1;
      idex_rd      = r;
      ifid_rs2     = r;
      ifid_use_rs2 = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      #1;
      // Outputs while reset is held
      check("rst_pc_write",   32'(d_pc_write), 0);
      check("rst_ifid_write", 32'(d_ifid_write), 0);
      check("rst_ifid_flush", 32'(d_ifid_flush), 1);
      check("rst_idex_flush", 32'(d_idex_flush), 1);
      check("rst_bubble",     32'(d_idex_bubble), 0);
      tick();
      reset = 1'b0;
      #1;
      check("idle_pc_write",   32'(d_pc_write), 1);
      check("idle_ifid_write", 32'(d_ifid_write), 1);
      check("idle_ifid_flush", 32'(d_ifid_flush), 0);
      check("idle_idex_flush", 32'(d_idex_flush), 0);
      check("idle_busy",       32'(d_busy), 0);
      check("idle_stall_cnt",  d_stall_cycles, 0);
      check("idle_flush_cnt",  d_flush_events, 0);
      check("idle_p_busy",     32'(p_busy), 0);

      // Single load-use, default parameters
      hazard_rs2(5'd5);
      #1;
      check("lu_pc_write",   32'(d_pc_write), 0);
      check("lu_ifid_write", 32'(d_ifid_write), 0);
      check("lu_bubble",     32'(d_idex_bubble), 1);
      check("lu_idex_flush", 32'(d_idex_flush), 0);
      tick();
      idle();
      #1;
      check("lu_after_bubble", 32'(d_idex_bubble), 0);
      check("lu_after_pcw",    32'(d_pc_write), 1);
      check("lu_after_busy",   32'(d_busy), 0);
      check("lu_stall_cnt",    d_stall_cycles, 1);
      // rd == x0 never stalls
      hazard_rs2(5'd0);
      #1;
      check("x0_bubble", 32'(d_idex_bubble), 0);
      check("x0_pcw",    32'(d_pc_write), 1);
      tick();
      // rs1 match with and without use_rs1
      idle();
      idex_memread = 1'b1;
      idex_rd      = 5'd7;
      ifid_rs1     = 5'd7;
      ifid_use_rs1 = 1'b1;
      #1;
      check("rs1_bubble", 32'(d_idex_bubble), 1);
      ifid_use_rs1 = 1'b0;
      #1;
      check("rs1_unused_bubble", 32'(d_idex_bubble), 0);
      idex_memread = 1'b0;
      ifid_use_rs1 = 1'b1;
      #1;
      check("noload_bubble", 32'(d_idex_bubble), 0);
      tick();
      check("rs_stall_cnt", d_stall_cycles, 1);

      // Branch and hazard together
      do_reset();
      hazard_rs2(5'd5);
      ex_branch_taken = 1'b1;
      #1;
      check("br_lu_idex_flush", 32'(d_idex_flush), 1);
      check("br_lu_ifid_flush", 32'(d_ifid_flush), 1);
      check("br_lu_bubble",     32'(d_idex_bubble), 0);
      check("br_lu_pcw",        32'(d_pc_write), 1);
      tick();
      idle();
      #1;
      check("br_lu_flush_cnt", d_flush_events, 1);
      check("br_lu_stall_cnt", d_stall_cycles, 0);
      check("br_lu_idex_flush_after", 32'(d_idex_flush), 0);

      // Multi-cycle load-use (3 cycles)
      do_reset();
      hazard_rs2(5'd9);
      #1;
      check("mlu_c1_bubble", 32'(p_idex_bubble), 1);
      check("mlu_c1_busy",   32'(p_busy), 0);
      tick();
      idle();
      #1;
      check("mlu_c2_bubble", 32'(p_idex_bubble), 1);
      check("mlu_c2_pcw",    32'(p_pc_write), 0);
      check("mlu_c2_busy",   32'(p_busy), 1);
      tick();
      check("mlu_c3_bubble", 32'(p_idex_bubble), 1);
      check("mlu_c3_busy",   32'(p_busy), 1);
      tick();
      check("mlu_c4_bubble", 32'(p_idex_bubble), 0);
      check("mlu_c4_pcw",    32'(p_pc_write), 1);
      check("mlu_c4_busy",   32'(p_busy), 0);
      check("mlu_stall_cnt", 32'(p_stall_cycles), 3);

      // Multi-cycle flush, hazard ignored in the second flush cycle
      do_reset();
      ex_branch_taken = 1'b1;
      #1;
      check("mfl_c1_idex_flush", 32'(p_idex_flush), 1);
      tick();
      ex_branch_taken = 1'b0;
      hazard_rs2(5'd3);
      #1;
      check("mfl_c2_idex_flush", 32'(p_idex_flush), 1);
      check("mfl_c2_ifid_flush", 32'(p_ifid_flush), 1);
      check("mfl_c2_bubble",     32'(p_idex_bubble), 0);
      check("mfl_c2_pcw",        32'(p_pc_write), 1);
      check("mfl_c2_busy",       32'(p_busy), 1);
      tick();
      idle();
      #1;
      check("mfl_c3_idex_flush", 32'(p_idex_flush), 0);
      check("mfl_c3_busy",       32'(p_busy), 0);
      check("mfl_flush_cnt",     32'(p_flush_events), 1);
      check("mfl_stall_cnt",     32'(p_stall_cycles), 0);

      // New branch during FLUSH extends it
      do_reset();
      ex_branch_taken = 1'b1;
      tick();
      #1;
      check("ext_c2_flush", 32'(p_idex_flush), 1);
      tick();
      ex_branch_taken = 1'b0;
      #1;
      check("ext_c3_flush", 32'(p_idex_flush), 1);
      check("ext_c3_busy",  32'(p_busy), 1);
      tick();
      check("ext_c4_flush",     32'(p_idex_flush), 0);
      check("ext_c4_busy",      32'(p_busy), 0);
      check("ext_flush_cnt",    32'(p_flush_events), 2);

      // Reset in the middle of LDSTALL
      do_reset();
      hazard_rs2(5'd4);
      tick();
      idle();
      #1;
      check("mid_busy_before", 32'(p_busy), 1);
      reset = 1'b1;
      #1;
      check("mid_rst_bubble",     32'(p_idex_bubble), 0);
      check("mid_rst_idex_flush", 32'(p_idex_flush), 1);
      check("mid_rst_pcw",        32'(p_pc_write), 0);
      tick();
      reset = 1'b0;
      #1;
      check("mid_after_busy",   32'(p_busy), 0);
      check("mid_after_bubble", 32'(p_idex_bubble), 0);
      check("mid_after_pcw",    32'(p_pc_write), 1);
      check("mid_after_cnt",    32'(p_stall_cycles), 0);

      // Counter saturation and clear
      do_reset();
      hazard_rs2(5'd6);
      for (int i = 0; i < 20; i++) tick();
      check("sat_p_stall_cnt", 32'(p_stall_cycles), 15);
      check("sat_d_stall_cnt", d_stall_cycles, 20);
      check("sat_p_bubble",    32'(p_idex_bubble), 1);
      perf_clear = 1'b1;
      tick();
      check("clr_p_stall_cnt", 32'(p_stall_cycles), 0);
      check("clr_d_stall_cnt", d_stall_cycles, 0);
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
